// File: rtl/rf_seq_pkg.sv
// Shared constants for the register-file command sequencer: data/address
// widths, opcode encoding and FSM state encoding.
package rf_seq_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;

  typedef enum logic [1:0] {
    OP_LDI = 2'b00,
    OP_MOV = 2'b01,
    OP_ADD = 2'b10,
    OP_RDR = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational result generator: immediate pass-through, copy of b,
// or 8-bit add with carry out. RDR reports the value read into b.
module rf_seq_alu
  import rf_seq_pkg::*;
(
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    result = b;
    carry  = 1'b0;
    case (op)
      OP_LDI: result = imm;
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      default: result = b;
    endcase
  end

endmodule

// File: rtl/rf_seq.sv
// Command sequencer driving a single-port register file: LDI/MOV/ADD/RDR
// executed as read/write cycle sequences, with registered outputs.
module rf_seq
  import rf_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rs,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              rf_enb,
  output logic              rf_r_w,
  output logic [ADDR_W-1:0] rf_sel,
  output logic [DATA_W-1:0] rf_in,
  input  logic [DATA_W-1:0] rf_out,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              flag_c,
  output logic              flag_z
);

  state_e              state, state_nxt;
  logic [1:0]          op_q, op_n;
  logic [ADDR_W-1:0]   rd_q, rd_n, rs_q, rs_n;
  logic [DATA_W-1:0]   imm_q, imm_n, a_q, a_n, b_q, b_n;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;
  logic                accept;

  assign accept = cmd_valid && cmd_ready;

  // The *_n values are what the latches hold after this edge; outputs are
  // registered from them so each output lines up with the state it belongs to.
  always_comb begin
    state_nxt = state;
    op_n      = op_q;
    rd_n      = rd_q;
    rs_n      = rs_q;
    imm_n     = imm_q;
    a_n       = a_q;
    b_n       = b_q;
    case (state)
      IDLE: begin
        if (accept) begin
          op_n  = cmd_op;
          rd_n  = cmd_rd;
          rs_n  = cmd_rs;
          imm_n = cmd_imm;
          case (cmd_op)
            OP_LDI:  state_nxt = WR;
            OP_ADD:  state_nxt = RD_A;
            default: state_nxt = RD_B;
          endcase
        end
      end
      RD_A: begin
        a_n       = rf_out;
        state_nxt = RD_B;
      end
      RD_B: begin
        b_n       = rf_out;
        state_nxt = (op_q == OP_RDR) ? DONE : WR;
      end
      WR:      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  rf_seq_alu u_alu (
    .op     (op_n),
    .imm    (imm_n),
    .a      (a_n),
    .b      (b_n),
    .result (alu_res),
    .carry  (alu_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      op_q  <= '0;
      rd_q  <= '0;
      rs_q  <= '0;
      imm_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      state <= state_nxt;
      op_q  <= op_n;
      rd_q  <= rd_n;
      rs_q  <= rs_n;
      imm_q <= imm_n;
      a_q   <= a_n;
      b_q   <= b_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_ready <= 1'b0;
      rf_enb    <= 1'b0;
      rf_r_w    <= 1'b1;
      rf_sel    <= '0;
      rf_in     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
    end else begin
      cmd_ready <= (state_nxt == IDLE);
      rf_enb    <= (state_nxt inside {RD_A, RD_B, WR});
      rf_r_w    <= (state_nxt != WR);
      case (state_nxt)
        RD_A, WR: rf_sel <= rd_n;
        RD_B:     rf_sel <= rs_n;
        default:  rf_sel <= '0;
      endcase
      rf_in     <= (state_nxt == WR) ? alu_res : '0;
      res_valid <= (state_nxt == DONE);
      if (state_nxt == DONE) begin
        res_data <= alu_res;
        flag_z   <= (alu_res == '0);
        if (op_n == OP_ADD)
          flag_c <= alu_c;
      end
    end
  end

endmodule

// File: tb/tb_rf_seq.sv
// Bench for rf_seq: a register-file model answers the DUT's port, and a
// transaction-level model predicts every output on every cycle.
module tb_rf_seq;

  localparam logic [1:0] LDI = 2'b00;
  localparam logic [1:0] MOV = 2'b01;
  localparam logic [1:0] ADD = 2'b10;
  localparam logic [1:0] RDR = 2'b11;
  localparam int N = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [3:0] cmd_rd = '0, cmd_rs = '0;
  logic [7:0] cmd_imm = '0;
  logic       rf_enb, rf_r_w;
  logic [3:0] rf_sel;
  logic [7:0] rf_in;
  logic [7:0] rf_out = '0;
  logic       res_valid;
  logic [7:0] res_data;
  logic       flag_c, flag_z;

  rf_seq dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_imm(cmd_imm),
    .rf_enb(rf_enb), .rf_r_w(rf_r_w), .rf_sel(rf_sel), .rf_in(rf_in),
    .rf_out(rf_out), .res_valid(res_valid), .res_data(res_data),
    .flag_c(flag_c), .flag_z(flag_z)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Register file: samples the port on the falling edge.
  logic [7:0] rf_mem [16];
  int wr_cnt = 0;
  initial begin
    for (int i = 0; i < 16; i++) rf_mem[i] = '0;
    forever begin
      @(negedge clk);
      if (rf_enb === 1'b1) begin
        if (rf_r_w === 1'b0) begin
          rf_mem[rf_sel] = rf_in;
          wr_cnt++;
        end else begin
          rf_out = rf_mem[rf_sel];
        end
      end
    end
  end

  // Expected activity per cycle: kind 0 = no access, 1 = read, 2 = write.
  int         kind [N];
  int         esel [N];
  int         ewd  [N];
  bit         dv   [N];
  int         dd   [N];
  bit         dcu  [N];
  bit         dc   [N];
  bit         dcm  [N];
  int         dca  [N];
  logic [7:0] mdl_mem [16];
  bit         in_reset = 1'b1;
  int         free_at = 0;
  int         n_done = 0;
  logic [7:0] m_data = '0;
  logic       m_c = 1'b0, m_z = 1'b0;
  bit         m_acc;
  logic [1:0] m_op;
  logic [3:0] m_rd, m_rs;
  logic [7:0] m_imm;

  task automatic set_done(input int t, input int d, input bit cu, input bit c,
                          input bit cm, input int ca);
    dv[t] = 1'b1; dd[t] = d; dcu[t] = cu; dc[t] = c; dcm[t] = cm; dca[t] = ca;
  endtask

  task automatic schedule(input int t);
    logic [8:0] s;
    case (m_op)
      LDI: begin
        kind[t] = 2; esel[t] = m_rd; ewd[t] = m_imm;
        set_done(t + 1, m_imm, 0, 0, 1, m_rd);
        free_at = t + 2;
      end
      MOV: begin
        kind[t] = 1; esel[t] = m_rs;
        kind[t+1] = 2; esel[t+1] = m_rd; ewd[t+1] = mdl_mem[m_rs];
        set_done(t + 2, mdl_mem[m_rs], 0, 0, 1, m_rd);
        free_at = t + 3;
      end
      ADD: begin
        s = {1'b0, mdl_mem[m_rd]} + {1'b0, mdl_mem[m_rs]};
        kind[t] = 1; esel[t] = m_rd;
        kind[t+1] = 1; esel[t+1] = m_rs;
        kind[t+2] = 2; esel[t+2] = m_rd; ewd[t+2] = s[7:0];
        set_done(t + 3, s[7:0], 1, s[8], 1, m_rd);
        free_at = t + 4;
      end
      default: begin
        kind[t] = 1; esel[t] = m_rs;
        set_done(t + 1, mdl_mem[m_rs], 0, 0, 0, 0);
        free_at = t + 2;
      end
    endcase
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mdl_mem[i] = '0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        in_reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
          kind[cyc+i] = 0;
          dv[cyc+i]   = 1'b0;
        end
        m_data = '0; m_c = 1'b0; m_z = 1'b0;
      end else begin
        m_acc = !in_reset && cmd_valid && (cyc >= free_at);
        m_op = cmd_op; m_rd = cmd_rd; m_rs = cmd_rs; m_imm = cmd_imm;
        cyc++;
        if (cyc + 8 >= N) begin
          $display("FAIL cycle_budget: got %0d, expected < %0d", cyc, N - 8);
          $fatal(1);
        end
        if (in_reset) begin
          in_reset = 1'b0;
          free_at  = cyc;
        end
        if (m_acc) schedule(cyc);
        if (dv[cyc]) begin
          m_data = dd[cyc][7:0];
          m_z    = (dd[cyc] == 0);
          if (dcu[cyc]) m_c = dc[cyc];
          if (dcm[cyc]) mdl_mem[dca[cyc]] = dd[cyc][7:0];
          n_done++;
        end
      end
    end
  end

  int n_valid = 0;
  initial begin
    int k;
    forever begin
      @(negedge clk);
      k = kind[cyc];
      check("cmd_ready", cmd_ready, int'(!in_reset && cyc >= free_at));
      check("rf_enb", rf_enb, int'(k != 0));
      check("rf_r_w", rf_r_w, int'(k != 2));
      if (k != 0) check("rf_sel", rf_sel, esel[cyc]);
      if (k != 1) check("rf_in", rf_in, (k == 2) ? ewd[cyc] : 0);
      check("res_valid", res_valid, int'(dv[cyc] && !in_reset));
      check("res_data", res_data, m_data);
      check("flag_c", flag_c, m_c);
      check("flag_z", flag_z, m_z);
      if (res_valid) n_valid++;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic [7:0] imm, output int lat);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_imm = imm;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    lat = -1;
    if (n >= 20) begin
      check("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_rd = 4'($urandom); cmd_rs = 4'($urandom); cmd_imm = 8'($urandom);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (res_valid) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) check("res_valid_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 0);
    check({tag, "_rf_enb"}, rf_enb, 0);
    check({tag, "_rf_r_w"}, rf_r_w, 1);
    check({tag, "_rf_sel"}, rf_sel, 0);
    check({tag, "_rf_in"}, rf_in, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_data"}, res_data, 0);
    check({tag, "_flag_c"}, flag_c, 0);
    check({tag, "_flag_z"}, flag_z, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish before 100000ns");
    $fatal(1);
  end

  initial begin
    int lat, w0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;

    w0 = wr_cnt;
    issue(LDI, 4'd3, 4'd0, 8'h5A, lat);
    check("ldi_latency", lat, 2);
    check("ldi_res_data", res_data, 8'h5A);
    check("ldi_flag_z", flag_z, 0);
    check("ldi_r3", rf_mem[3], 8'h5A);
    check("ldi_writes", wr_cnt - w0, 1);

    issue(LDI, 4'd1, 4'd0, 8'hF0, lat);
    issue(LDI, 4'd2, 4'd0, 8'h20, lat);
    issue(ADD, 4'd1, 4'd2, 8'h00, lat);
    check("add_latency", lat, 4);
    check("add_res_data", res_data, 8'h10);
    check("add_flag_c", flag_c, 1);
    check("add_r1", rf_mem[1], 8'h10);

    issue(MOV, 4'd7, 4'd1, 8'hFF, lat);
    check("mov_latency", lat, 3);
    check("mov_r7", rf_mem[7], 8'h10);
    check("mov_flag_c", flag_c, 1);

    w0 = wr_cnt;
    issue(RDR, 4'd9, 4'd7, 8'h00, lat);
    check("rdr_latency", lat, 2);
    check("rdr_res_data", res_data, 8'h10);
    check("rdr_writes", wr_cnt - w0, 0);

    issue(LDI, 4'd4, 4'd0, 8'h80, lat);
    issue(ADD, 4'd4, 4'd4, 8'h00, lat);
    check("dbl_r4", rf_mem[4], 8'h00);
    check("dbl_flag_c", flag_c, 1);
    check("dbl_flag_z", flag_z, 1);

    // Reset lands in the second read cycle of an ADD.
    issue(LDI, 4'd5, 4'd0, 8'h33, lat);
    w0 = wr_cnt;
    @(negedge clk);
    check("abort_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = ADD; cmd_rd = 4'd5; cmd_rs = 4'd5;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (3) @(negedge clk);
    check("abort_r5", rf_mem[5], 8'h33);
    check("abort_writes", wr_cnt - w0, 0);
    rst = 1'b1;
    issue(LDI, 4'd6, 4'd0, 8'h77, lat);
    check("post_rst_latency", lat, 2);
    check("post_rst_r6", rf_mem[6], 8'h77);
    check("post_rst_res_data", res_data, 8'h77);

    // cmd_valid held high while the fields keep changing.
    @(negedge clk);
    cmd_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cmd_op = 2'($urandom); cmd_rd = 4'($urandom); cmd_rs = 4'($urandom); cmd_imm = 8'($urandom);
      @(negedge clk);
    end

    for (int i = 0; i < 1200; i++) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_op = 2'($urandom); cmd_rd = 4'($urandom); cmd_rs = 4'($urandom); cmd_imm = 8'($urandom);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    repeat (8) @(negedge clk);

    check("valid_count", n_valid, n_done);
    for (int i = 0; i < 16; i++) check($sformatf("final_r%0d", i), rf_mem[i], mdl_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
